dr_injector: RTL and testbench
==============================

// Module: dr_injector
// PURPOSE
//  Clocked front-end for the dual-rail datapath. Accepts one single-rail word per transfer on a valid/ready handshake and
//  drives it as a dual-rail codeword on X_1/X_0 pairs into the ndr gate network, whose per-bit OR feeds an 8-input
//  completion detector (cp08d1 class) that returns cd_q. Enforces the four-phase protocol: codeword, wait full completion,
//  spacer, wait full release. Synchronises cd_q and flags a completion timeout.
// PARAMETERS
//  W        8     data width; one rail pair per bit; W>=1
//  SP       0     spacer polarity: 0 -> spacer is X_1=X_0=0 (sp0); 1 -> spacer is X_1=X_0=1 (sp1)
//  SYNC     2     cd_q synchroniser depth in flops, 1..3
//  TIMEOUT  255   cycles allowed per wait phase before err; 8-bit counter, 1..255
// PORTS
//  clk       in   1  clock, rising edge
//  rst       in   1  synchronous reset, active high
//  in_valid  in   1  upstream word valid
//  in_data   in   W  upstream single-rail word
//  in_ready  out  1  block can accept a word this cycle
//  cd_q      in   1  completion detector output: 1 = all bits hold codeword, 0 = all bits spacer (asynchronous)
//  X_1       out  W  true rails
//  X_0       out  W  false rails
//  busy      out  1  a transfer is in flight (state != IDLE)
//  err       out  1  sticky timeout flag; cleared only by rst
//  xfer_cnt  out  16 completed transfers, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Encoding: codeword bit b -> X_1[b]=b, X_0[b]=~b. Spacer -> both rails = SP. All outputs registered.
//  cd_s = cd_q through SYNC flops, each reset to 0. Under SP=1, cd_s is inverted once after the synchroniser,
//   so "complete" is always cd_s=1.
//  FSM: IDLE, DATA, SPC.
//   IDLE: in_ready=1. When in_valid, capture in_data, drive codeword next cycle, go to DATA, clear timer.
//   DATA: in_ready=0. Hold codeword. When cd_s=1, drive spacer next cycle, go to SPC, clear timer.
//   SPC:  in_ready=0. Hold spacer. When cd_s=0, increment xfer_cnt, go to IDLE.
//   Timer: counts each cycle spent in DATA or SPC. On reaching TIMEOUT, set err.
//    - In DATA on timeout: force spacer and go to SPC.
//    - In SPC on timeout: go to IDLE without incrementing xfer_cnt.
//  Latency:
//   - Accept at edge t -> codeword visible after edge t; spacer driven the cycle after cd_s is seen 1.
//   - Minimum transfer is 2*(SYNC+1)+1 cycles with an instant detector.
//  No back-to-back accept: in_ready is 0 from the cycle after acceptance until the return to IDLE.
//  Completion during the acceptance cycle is ignored; only cd_s sampled in DATA counts.
//  Timeout and completion in the same cycle: completion wins, err unchanged.
//  Reset values (any state, mid-transfer included): state=IDLE, X_1=X_0={W{SP}} (spacer), in_ready=1 in the first cycle
//   after reset, busy=0, err=0, xfer_cnt=0, sync flops=0, timer=0.
//  in_data is sampled only on acceptance; changes while busy have no effect.
//  Outputs never show a mixed codeword/spacer word for more than one edge, since all bits are from the same register.
// TESTING
//  1. Reset, W=8, SP=0. in_data=0xA5 valid 1 cycle; model cd_q=1 three cycles later, 0 three cycles after spacer ->
//     X_1=0xA5, X_0=0x5A, then 0x00/0x00; xfer_cnt=1; err=0.
//  2. in_valid held high, 0x01,0x02,0x03 queued by the driver -> exactly three transfers in order, in_ready low between
//     them, xfer_cnt=3.
//  3. cd_q never rises, TIMEOUT=20 -> err=1 at the 20th DATA cycle, spacer driven, return to IDLE, xfer_cnt unchanged.
//  4. SP=1, in_data=0x0F -> X_1=0x0F, X_0=0xF0, then spacer 0xFF/0xFF; completion is taken from inverted cd_q.
//  5. rst asserted while in DATA with 0x3C driven -> next cycle spacer, IDLE, busy=0, err=0, xfer_cnt=0.
//  6. cd_q glitches high for less than one cycle in DATA, not captured by the synchroniser -> no transition; a held
//     cd_q=1 then completes normally.

Source files
------------

// File: rtl/dr_injector.sv
// dr_injector: clocked front-end that injects single-rail words into a dual-rail
// datapath as codeword/spacer pairs on X_1/X_0 under a four-phase protocol.
// Latency: codeword visible after the accept edge; spacer one cycle after the
// synchronised completion is seen; back to IDLE one cycle after release is seen.
// Backpressure: in_ready is high only in IDLE, so no back-to-back accepts.
// Ports: clk/rst (sync, active high); in_valid/in_data/in_ready upstream handshake;
// cd_q async completion detector input; X_1/X_0 rail outputs; busy, sticky err,
// 16-bit wrapping xfer_cnt of completed transfers.
module dr_injector #(
  parameter int W       = 8,
  parameter int SP      = 0,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          cd_q,
  output logic [W-1:0]  X_1,
  output logic [W-1:0]  X_0,
  output logic          busy,
  output logic          err,
  output logic [15:0]   xfer_cnt
);

  localparam logic         LP_SP       = (SP != 0);
  localparam logic [W-1:0] LP_SPACER   = {W{LP_SP}};
  localparam logic [7:0]   LP_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_SPC} state_t;

  state_t          r_state, w_state_nxt;
  logic [SYNC-1:0] r_sync;
  logic            w_cd_s;
  logic [7:0]      r_timer, w_timer_nxt;
  logic [W-1:0]    r_x1, r_x0, w_x1_nxt, w_x0_nxt;
  logic            r_err, w_err_nxt;
  logic            r_abort, w_abort_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;

  // cd_q is asynchronous to clk: plain flop chain, oldest stage is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= cd_q;
      for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // With an sp1 spacer the detector sense is flipped so that 1 always means complete.
  assign w_cd_s = r_sync[SYNC-1] ^ LP_SP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_x1    <= LP_SPACER;
      r_x0    <= LP_SPACER;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_x1    <= w_x1_nxt;
      r_x0    <= w_x0_nxt;
      r_err   <= w_err_nxt;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_x1_nxt    = r_x1;
    w_x0_nxt    = r_x0;
    w_err_nxt   = r_err;
    w_abort_nxt = r_abort;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        // Completion seen here is ignored; only DATA-phase samples count.
        if (in_valid) begin
          w_x1_nxt    = in_data;
          w_x0_nxt    = ~in_data;
          w_state_nxt = ST_DATA;
          w_timer_nxt = '0;
          w_abort_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        // Completion is checked first so it wins over a simultaneous timeout.
        if (w_cd_s) begin
          w_x1_nxt    = LP_SPACER;
          w_x0_nxt    = LP_SPACER;
          w_state_nxt = ST_SPC;
          w_timer_nxt = '0;
        end else if (r_timer == LP_TMO_LAST) begin
          // Force the spacer so the network is still returned to a clean state.
          w_err_nxt   = 1'b1;
          w_abort_nxt = 1'b1;
          w_x1_nxt    = LP_SPACER;
          w_x0_nxt    = LP_SPACER;
          w_state_nxt = ST_SPC;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ST_SPC: begin
        if (!w_cd_s) begin
          // A word whose codeword phase timed out never completed, so it is not counted.
          if (!r_abort) w_cnt_nxt = r_cnt + 16'd1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == LP_TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign X_1      = r_x1;
  assign X_0      = r_x0;
  assign err      = r_err;
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_dr_injector.sv
// Bench for dr_injector: an sp0 instance (short timeout) carries directed and random
// transfers with the bench acting as completion detector; an sp1 instance checks the
// inverted-spacer encoding and inverted completion sense.
module tb_dr_injector;
  localparam int SYNC = 2;
  localparam int TMO  = 20;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, cd_q, busy, err;
  logic [7:0]  in_data, x1, x0;
  logic [15:0] xfer_cnt;
  logic        v1, rdy1, cd1, busy1, err1;
  logic [7:0]  d1, x1b, x0b;
  logic [15:0] cnt1;

  int          tests = 0;
  int          fails = 0;
  int          exp_cnt = 0;
  logic        exp_err = 1'b0;

  dr_injector #(.W(8), .SP(0), .SYNC(SYNC), .TIMEOUT(TMO)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cd_q(cd_q), .X_1(x1), .X_0(x0), .busy(busy), .err(err), .xfer_cnt(xfer_cnt)
  );

  dr_injector #(.W(8), .SP(1), .SYNC(SYNC), .TIMEOUT(TMO)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .cd_q(cd1), .X_1(x1b), .X_0(x0b), .busy(busy1), .err(err1), .xfer_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full four-phase transfer on the sp0 instance. dc/dr are the detector's
  // response delays in cycles; glitch adds sub-cycle cd_q pulses while waiting.
  task automatic do_xfer(input logic [7:0] d, input int dc, input int dr,
                         input bit glitch, input bit hold, input logic [7:0] nxt);
    logic [7:0] cw1, cw0;
    cw1 = d;
    cw0 = ~d;
    in_data  = d;
    in_valid = 1'b1;
    tick;
    chk("acc_x1", x1, cw1);
    chk("acc_x0", x0, cw0);
    chk("acc_rdy", in_ready, 0);
    chk("acc_busy", busy, 1);
    if (hold) in_data = nxt;
    else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    for (int i = 0; i < dc; i++) begin
      if (glitch) begin
        cd_q = 1'b1;
        #2;
        cd_q = 1'b0;
      end
      tick;
      chk("data_hold_x1", x1, cw1);
      chk("data_hold_x0", x0, cw0);
      chk("data_hold_rdy", in_ready, 0);
    end
    cd_q = 1'b1;
    for (int i = 0; i < SYNC; i++) begin
      tick;
      chk("sync_wait_x1", x1, cw1);
    end
    tick;
    chk("spc_x1", x1, 0);
    chk("spc_x0", x0, 0);
    chk("spc_busy", busy, 1);
    for (int i = 0; i < dr; i++) begin
      tick;
      chk("spc_hold_x1", x1, 0);
      chk("spc_hold_busy", busy, 1);
    end
    cd_q = 1'b0;
    for (int i = 0; i < SYNC; i++) begin
      tick;
      chk("rel_wait_busy", busy, 1);
      chk("rel_wait_rdy", in_ready, 0);
    end
    tick;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk("done_busy", busy, 0);
    chk("done_rdy", in_ready, 1);
    chk("done_cnt", xfer_cnt, exp_cnt);
    chk("done_err", err, exp_err);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cd_q = 1'b0;
    v1 = 1'b0; d1 = 8'h00; cd1 = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_x1", x1, 8'h00);
    chk("rst_x0", x0, 8'h00);
    chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", xfer_cnt, 0);

    // Single transfer, detector answers three cycles after each phase.
    do_xfer(8'hA5, 3, 3, 1'b0, 1'b0, 8'h00);

    // Valid held high with a queue of three words.
    do_xfer(8'h01, 1, 1, 1'b0, 1'b1, 8'h02);
    do_xfer(8'h02, 2, 0, 1'b0, 1'b1, 8'h03);
    do_xfer(8'h03, 0, 2, 1'b0, 1'b0, 8'h00);
    repeat (3) begin
      tick;
      chk("q_idle_cnt", xfer_cnt, exp_cnt);
      chk("q_idle_busy", busy, 0);
    end

    // Sub-cycle glitches on cd_q during DATA must not complete the word.
    do_xfer(8'hC3, 4, 2, 1'b1, 1'b0, 8'h00);

    // Random words, detector delays and idle gaps.
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        chk("gap_rdy", in_ready, 1);
        chk("gap_x1", x1, 0);
      end
      do_xfer(8'($urandom), $urandom_range(0, 8), $urandom_range(0, 8),
              1'($urandom_range(0, 1)), 1'b0, 8'h00);
    end

    // Detector never completes: timeout on the TMO-th DATA cycle.
    in_data = 8'h5E; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("tmo_acc_x1", x1, 8'h5E);
    for (int i = 1; i < TMO; i++) begin
      tick;
      chk("tmo_wait_err", err, 0);
      chk("tmo_wait_x1", x1, 8'h5E);
    end
    tick;
    exp_err = 1'b1;
    chk("tmo_err", err, 1);
    chk("tmo_spc_x1", x1, 0);
    chk("tmo_spc_x0", x0, 0);
    tick;
    chk("tmo_idle_busy", busy, 0);
    chk("tmo_cnt", xfer_cnt, exp_cnt);
    chk("tmo_err_sticky", err, 1);

    // Reset in the middle of DATA.
    in_data = 8'h3C; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("mid_x1", x1, 8'h3C);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0; exp_err = 1'b0;
    chk("mid_rst_x1", x1, 0);
    chk("mid_rst_x0", x0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);

    // sp1 instance: spacer is all-ones, completion taken from inverted cd_q.
    chk("sp1_rst_x1", x1b, 8'hFF);
    chk("sp1_rst_x0", x0b, 8'hFF);
    repeat (4) tick;
    d1 = 8'h0F; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    chk("sp1_x1", x1b, 8'h0F);
    chk("sp1_x0", x0b, 8'hF0);
    repeat (2) tick;
    chk("sp1_hold_x1", x1b, 8'h0F);
    cd1 = 1'b0;
    repeat (SYNC) tick;
    chk("sp1_sync_x1", x1b, 8'h0F);
    tick;
    chk("sp1_spc_x1", x1b, 8'hFF);
    chk("sp1_spc_x0", x0b, 8'hFF);
    repeat (2) tick;
    cd1 = 1'b1;
    repeat (SYNC) tick;
    chk("sp1_rel_busy", busy1, 1);
    tick;
    chk("sp1_done_busy", busy1, 0);
    chk("sp1_done_cnt", cnt1, 1);
    chk("sp1_done_err", err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
